// File: rtl/integer_execute_if.sv
// Issue, result-broadcast, ROB-completion and fetch-redirect signals of the integer execute unit.
interface integer_execute_if #(
  parameter int XLEN         = 32,
  parameter int ROB_ID_WIDTH = 5
);
  logic                    issue_valid;
  logic [XLEN-1:0]         src1_data;
  logic [XLEN-1:0]         src2_data;
  logic [XLEN-1:0]         imm;
  logic [XLEN-1:0]         pc;
  logic [ROB_ID_WIDTH-1:0] rob_id;
  logic [2:0]              funct3;
  logic                    is_r_type;
  logic                    is_i_type;
  logic                    is_u_type;
  logic                    is_b_type;
  logic                    is_j_type;
  logic                    is_sub;
  logic                    is_sra_srai;
  logic                    is_lui;
  logic                    is_jalr;
  logic                    dst_valid;
  logic                    br_dir_pred;
  logic [XLEN-1:0]         br_target_pred;

  logic                    alu_broadcast_valid;
  logic [ROB_ID_WIDTH-1:0] alu_broadcast_rob_id;
  logic [XLEN-1:0]         alu_broadcast_reg_data;
  logic                    rob_complete_valid;
  logic [ROB_ID_WIDTH-1:0] rob_complete_rob_id;
  logic                    rob_complete_mispred;
  logic                    redirect_valid;
  logic [XLEN-1:0]         redirect_pc;
  logic                    redirect_ready;
  logic [31:0]             mispred_count;

  modport master (
    output issue_valid, src1_data, src2_data, imm, pc, rob_id, funct3,
           is_r_type, is_i_type, is_u_type, is_b_type, is_j_type, is_sub,
           is_sra_srai, is_lui, is_jalr, dst_valid, br_dir_pred, br_target_pred,
           redirect_ready,
    input  alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
           rob_complete_valid, rob_complete_rob_id, rob_complete_mispred,
           redirect_valid, redirect_pc, mispred_count
  );

  modport slave (
    input  issue_valid, src1_data, src2_data, imm, pc, rob_id, funct3,
           is_r_type, is_i_type, is_u_type, is_b_type, is_j_type, is_sub,
           is_sra_srai, is_lui, is_jalr, dst_valid, br_dir_pred, br_target_pred,
           redirect_ready,
    output alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
           rob_complete_valid, rob_complete_rob_id, rob_complete_mispred,
           redirect_valid, redirect_pc, mispred_count
  );
endinterface

// File: rtl/integer_execute.sv
// Single-cycle integer ALU / branch-resolution unit with registered results and a
// RUN/REDIRECT squash FSM driving the fetch redirect handshake.
module integer_execute #(
  parameter int XLEN         = 32,
  parameter int ROB_ID_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  integer_execute_if.slave  bus
);

  typedef enum logic [0:0] {RUN, REDIRECT} state_t;

  state_t          state, state_next;
  logic            accept;
  logic [XLEN-1:0] op_b, alu_res, result;
  logic [XLEN-1:0] pc_plus4, jalr_sum, br_target, actual_next, pred_next;
  logic [4:0]      shamt;
  logic            br_cond, taken, is_ctrl, mispred;

  always_comb begin
    op_b  = bus.is_r_type ? bus.src2_data : bus.imm;
    shamt = op_b[4:0];
    alu_res = '0;
    unique case (bus.funct3)
      3'b000: alu_res = (bus.is_r_type && bus.is_sub) ? bus.src1_data - op_b
                                                      : bus.src1_data + op_b;
      3'b001: alu_res = bus.src1_data << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.src1_data) < $signed(op_b)};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, bus.src1_data < op_b};
      3'b100: alu_res = bus.src1_data ^ op_b;
      3'b101: alu_res = bus.is_sra_srai ? XLEN'($signed(bus.src1_data) >>> shamt)
                                        : bus.src1_data >> shamt;
      3'b110: alu_res = bus.src1_data | op_b;
      3'b111: alu_res = bus.src1_data & op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    pc_plus4 = bus.pc + XLEN'(4);
    jalr_sum = bus.src1_data + bus.imm;

    // Jumps take priority so a jalr also flagged as I-type still links pc+4.
    if (bus.is_jalr || bus.is_j_type) result = pc_plus4;
    else if (bus.is_u_type)           result = bus.is_lui ? bus.imm : bus.pc + bus.imm;
    else                              result = alu_res;

    br_cond = 1'b0;
    case (bus.funct3)
      3'b000: br_cond = bus.src1_data == bus.src2_data;
      3'b001: br_cond = bus.src1_data != bus.src2_data;
      3'b100: br_cond = $signed(bus.src1_data) <  $signed(bus.src2_data);
      3'b101: br_cond = $signed(bus.src1_data) >= $signed(bus.src2_data);
      3'b110: br_cond = bus.src1_data <  bus.src2_data;
      3'b111: br_cond = bus.src1_data >= bus.src2_data;
      default: br_cond = 1'b0;
    endcase

    is_ctrl     = bus.is_b_type || bus.is_j_type || bus.is_jalr;
    taken       = bus.is_j_type || bus.is_jalr || (bus.is_b_type && br_cond);
    br_target   = bus.is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : bus.pc + bus.imm;
    actual_next = taken ? br_target : pc_plus4;
    pred_next   = bus.br_dir_pred ? bus.br_target_pred : pc_plus4;
    mispred     = is_ctrl && (actual_next != pred_next);
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      RUN: begin
        accept = bus.issue_valid;
        if (accept && mispred) state_next = REDIRECT;
      end
      REDIRECT: begin
        if (bus.redirect_ready) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  assign bus.redirect_valid = (state == REDIRECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_broadcast_valid    <= 1'b0;
      bus.alu_broadcast_rob_id   <= '0;
      bus.alu_broadcast_reg_data <= '0;
      bus.rob_complete_valid     <= 1'b0;
      bus.rob_complete_rob_id    <= '0;
      bus.rob_complete_mispred   <= 1'b0;
      bus.redirect_pc            <= '0;
      bus.mispred_count          <= '0;
    end else begin
      bus.alu_broadcast_valid <= accept && bus.dst_valid;
      bus.rob_complete_valid  <= accept;
      if (accept) begin
        bus.alu_broadcast_rob_id   <= bus.rob_id;
        bus.alu_broadcast_reg_data <= result;
        bus.rob_complete_rob_id    <= bus.rob_id;
        bus.rob_complete_mispred   <= mispred;
      end
      if (accept && mispred) begin
        bus.redirect_pc   <= actual_next;
        bus.mispred_count <= bus.mispred_count + 32'd1;
      end
    end
  end

endmodule
